// File: rtl/pwm_fade_sequencer_pkg.sv
// Shared types and helpers for the breathing-light LED controller.
// Holds the state encoding and the saturating duty arithmetic.
package pwm_fade_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UP      = 3'd1,
    S_HOLD_HI = 3'd2,
    S_DOWN    = 3'd3,
    S_HOLD_LO = 3'd4
  } state_t;

  localparam logic [7:0] DUTY_MAX = 8'd255;

  function automatic logic [7:0] duty_up(
    input logic [7:0] d,
    input logic [7:0] s
  );
    logic [8:0] sum;
    sum = {1'b0, d} + {1'b0, s};
    return (sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : sum[7:0];
  endfunction

  function automatic logic [7:0] duty_dn(
    input logic [7:0] d,
    input logic [7:0] s
  );
    logic [8:0] dif;
    dif = {1'b0, d} - {1'b0, s};
    return dif[8] ? 8'd0 : dif[7:0];
  endfunction

endpackage

// File: rtl/pwm_fade_sequencer_pwm_core.sv
// PWM period counter and duty comparator with a registered output.
// The counter idles at zero while disabled so each run starts phase-aligned.
module pwm_core
  import pwm_fade_sequencer_pkg::*;
#(
  parameter int PERIOD = 256,
  parameter int DIV    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] duty,
  output logic       pwm,
  output logic       boundary
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TW = CW + 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;
  logic [TW-1:0] thr;

  // 255*DIV < PERIOD, so the product always fits in TW bits
  assign thr      = TW'(duty) * TW'(DIV);
  assign boundary = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else if (!enable) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else begin
      pwm <= ({1'b0, cnt} < thr);
      cnt <= boundary ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Breathing-light sequencer: ramps PWM duty up, holds, ramps down, holds.
// Drives the LED bank in unison or as a rotating single-LED chase.
module pwm_fade_sequencer
  import pwm_fade_sequencer_pkg::*;
#(
  parameter int CLK_FREQ     = 25_000_000,
  parameter int PWM_FREQ     = 50,
  parameter int STEP         = 4,
  parameter int HOLD_PERIODS = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  output logic [7:0] leds,
  output logic       busy,
  output logic [7:0] duty,
  output logic       cycle_done
);

  localparam int PWM_PERIOD = CLK_FREQ / PWM_FREQ;
  localparam int DIV        = PWM_PERIOD / 256;
  localparam int HW         = $clog2(HOLD_PERIODS + 1);
  localparam logic [7:0]    STEP_V    = 8'(STEP);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_PERIODS - 1);

  state_t        state, state_d;
  logic [7:0]    duty_d;
  logic [2:0]    idx, idx_d;
  logic [HW-1:0] hold, hold_d;
  logic          mode_q, mode_d;
  logic          pend, pend_d;
  logic          done_d;
  logic          stop_now;
  logic          pwm;
  logic          boundary;

  pwm_core #(
    .PERIOD(PWM_PERIOD),
    .DIV   (DIV)
  ) u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (busy),
    .duty    (duty),
    .pwm     (pwm),
    .boundary(boundary)
  );

  assign busy = (state != S_IDLE);
  assign leds = mode_q ? ({7'b0, pwm} << idx) : {8{pwm}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      duty       <= '0;
      idx        <= '0;
      hold       <= '0;
      mode_q     <= 1'b0;
      pend       <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      state      <= state_d;
      duty       <= duty_d;
      idx        <= idx_d;
      hold       <= hold_d;
      mode_q     <= mode_d;
      pend       <= pend_d;
      cycle_done <= done_d;
    end
  end

  always_comb begin
    state_d  = state;
    duty_d   = duty;
    idx_d    = idx;
    hold_d   = hold;
    mode_d   = mode_q;
    pend_d   = pend;
    done_d   = 1'b0;
    stop_now = stop || pend;
    if (state == S_IDLE) begin
      if (start && !stop) begin
        state_d = S_UP;
        duty_d  = '0;
        idx_d   = '0;
        hold_d  = '0;
        mode_d  = mode;
      end
    end else begin
      if (stop) pend_d = 1'b1;
      // a pending stop beats any phase transition at the boundary
      if (boundary && stop_now) begin
        state_d = S_IDLE;
        duty_d  = '0;
        hold_d  = '0;
        pend_d  = 1'b0;
      end else if (boundary) begin
        unique case (state)
          S_UP: begin
            duty_d = duty_up(duty, STEP_V);
            if (duty_d == DUTY_MAX) begin
              state_d = S_HOLD_HI;
              hold_d  = '0;
            end
          end
          S_HOLD_HI: begin
            if (hold == HOLD_LAST) begin
              state_d = S_DOWN;
              hold_d  = '0;
            end else begin
              hold_d = hold + HW'(1);
            end
          end
          S_DOWN: begin
            duty_d = duty_dn(duty, STEP_V);
            if (duty_d == 8'd0) begin
              state_d = S_HOLD_LO;
              hold_d  = '0;
            end
          end
          S_HOLD_LO: begin
            if (hold == HOLD_LAST) begin
              state_d = S_UP;
              hold_d  = '0;
              idx_d   = idx + 3'd1;
              done_d  = 1'b1;
            end else begin
              hold_d = hold + HW'(1);
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Scoreboard bench for pwm_fade_sequencer: a per-period duty profile model
// predicts timed busy/duty/cycle_done events and per-period LED patterns.
module tb_pwm_fade_sequencer;

  localparam int CLK_F = 2560;
  localparam int PWM_F = 10;
  localparam int STEP  = 64;
  localparam int HOLD  = 2;
  localparam int P     = CLK_F / PWM_F;
  localparam int DIV   = P / 256;

  typedef struct {
    int t;
    int v;
  } ev_t;

  typedef struct {
    int         t;
    int         h;
    logic [7:0] m;
  } win_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] leds;
  logic       busy;
  logic [7:0] duty;
  logic       cycle_done;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   prof[$];
  int   L;
  ev_t  bq[$];
  ev_t  dq[$];
  ev_t  cq[$];
  win_t wq[$];

  pwm_fade_sequencer #(
    .CLK_FREQ    (CLK_F),
    .PWM_FREQ    (PWM_F),
    .STEP        (STEP),
    .HOLD_PERIODS(HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .leds      (leds),
    .busy      (busy),
    .duty      (duty),
    .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_500_000;
    $display("FAIL watchdog cyc=%0d required finish earlier", cyc);
    $fatal(1, "timeout");
  end

  function automatic int pval(input int k);
    return prof[k % L];
  endfunction

  // one breathing cycle as a list of per-period duty values
  task automatic build_prof();
    int v;
    v = 0;
    while (v < 255) begin
      prof.push_back(v);
      v = (v + STEP > 255) ? 255 : v + STEP;
    end
    repeat (HOLD + 1) prof.push_back(255);
    v = (255 - STEP < 0) ? 0 : 255 - STEP;
    while (v > 0) begin
      prof.push_back(v);
      v = (v - STEP < 0) ? 0 : v - STEP;
    end
    repeat (HOLD) prof.push_back(0);
    L = prof.size();
  endtask

  task automatic plan(input int t0, input bit md, input int n, input bit stp);
    logic [7:0] one;
    logic [7:0] m;
    one = 8'h01;
    bq.push_back('{t0, 1});
    for (int k = 0; k < n; k++) begin
      m = md ? (one << ((k / L) % 8)) : 8'hFF;
      wq.push_back('{t0 + P * k + 1, pval(k) * DIV, m});
    end
    for (int k = 1; k < n; k++)
      if (pval(k) != pval(k - 1)) dq.push_back('{t0 + P * k, pval(k)});
    for (int k = L; k < n; k += L) cq.push_back('{t0 + P * k, 1});
    if (stp) begin
      bq.push_back('{t0 + P * n, 0});
      if (pval(n - 1) != 0) dq.push_back('{t0 + P * n, 0});
    end else if (pval(n) != pval(n - 1)) begin
      dq.push_back('{t0 + P * n, pval(n)});
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic ev_chk(input string nm, input bit have, input ev_t e, input int v);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s unexpected change cyc=%0d got %0d", nm, cyc, v);
    end else if (e.t != cyc || e.v != v) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0d expected cyc=%0d value %0d",
               nm, cyc, v, e.t, e.v);
    end
  endtask

  logic [7:0] pduty;
  logic       pbusy;
  int         hi_n = 0;
  int         bad_n = 0;
  ev_t        me;

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy !== pbusy) begin
        if (bq.size() == 0) ev_chk("busy", 1'b0, '{0, 0}, int'(busy));
        else begin
          me = bq.pop_front();
          ev_chk("busy", 1'b1, me, int'(busy));
        end
      end
      if (duty !== pduty) begin
        if (dq.size() == 0) ev_chk("duty", 1'b0, '{0, 0}, int'(duty));
        else begin
          me = dq.pop_front();
          ev_chk("duty", 1'b1, me, int'(duty));
        end
      end
      if (cycle_done === 1'b1) begin
        if (cq.size() == 0) ev_chk("cycle_done", 1'b0, '{0, 0}, 1);
        else begin
          me = cq.pop_front();
          ev_chk("cycle_done", 1'b1, me, 1);
        end
      end
      if (wq.size() != 0 && cyc >= wq[0].t) begin
        if (leds === wq[0].m) hi_n++;
        else if (leds !== 8'h00) bad_n++;
        if (cyc == wq[0].t + P - 1) begin
          checks++;
          if (hi_n != wq[0].h || bad_n != 0) begin
            errors++;
            $display("FAIL leds_period t=%0d high=%0d bad=%0d expected high=%0d mask=%h",
                     wq[0].t, hi_n, bad_n, wq[0].h, wq[0].m);
          end
          void'(wq.pop_front());
          hi_n  = 0;
          bad_n = 0;
        end
      end else begin
        checks++;
        if (leds !== 8'h00) begin
          errors++;
          $display("FAIL leds_idle cyc=%0d got %h expected 00", cyc, leds);
        end
      end
    end
    pbusy = busy;
    pduty = duty;
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic run(input bit md, input int n, input int off);
    int t0;
    mode  = md;
    start = 1'b1;
    t0    = cyc + 1;
    plan(t0, md, n, 1'b1);
    tick();
    start = 1'b0;
    repeat (49) tick();
    start = 1'b1;
    mode  = ~md;
    tick();
    start = 1'b0;
    while (cyc < t0 + P * (n - 1) + off) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    while (cyc < t0 + P * n + 2) tick();
    chk("busy_after_stop", int'(busy), 0);
    chk("duty_after_stop", int'(duty), 0);
  endtask

  initial begin
    int t0;
    build_prof();
    #1;
    chk("rst_leds", int'(leds), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_duty", int'(duty), 0);
    chk("rst_cycle_done", int'(cycle_done), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
    repeat (1000) tick();

    run(1'b0, 14, $urandom_range(0, P - 1));
    repeat (20) tick();
    run(1'b1, 9 * L, $urandom_range(0, P - 1));
    run(1'b0, 8, $urandom_range(1, P - 2));
    run(1'b0, 3, P - 1);

    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    repeat (300) tick();
    chk("start_stop_idle_busy", int'(busy), 0);
    chk("start_stop_idle_duty", int'(duty), 0);

    mode  = 1'b0;
    start = 1'b1;
    t0    = cyc + 1;
    plan(t0, 1'b0, 4, 1'b0);
    tick();
    start = 1'b0;
    while (cyc < t0 + 4 * P) tick();
    mon_en = 1'b0;
    while (cyc < t0 + 4 * P + 100) tick();
    chk("hold_hi_busy_before_rst", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_leds", int'(leds), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_duty", int'(duty), 0);
    chk("async_rst_cycle_done", int'(cycle_done), 0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_duty", int'(duty), 0);
    chk("post_rst_leds", int'(leds), 0);
    mon_en = 1'b1;

    repeat (3) run(1'(($urandom_range(0, 1))), $urandom_range(2, 20),
                   $urandom_range(0, P - 1));
    repeat (300) tick();

    chk("busy_events_left", bq.size(), 0);
    chk("duty_events_left", dq.size(), 0);
    chk("done_events_left", cq.size(), 0);
    chk("periods_left", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_fade_sequencer.md
# pwm_fade_sequencer

Breathing-light controller for the board LED bank. It owns the PWM period counter and comparator, and sequences the duty cycle through ramp-up, hold-high, ramp-down and hold-low phases. It drives `leds[7:0]` either in unison or as a rotating single-LED chase. It replaces the fixed 50 % PWM driver at the top level and is controlled by start/stop strobes from the button/debounce logic.

## Interface
- `CLK_FREQ`, 25_000_000, system clock in Hz.
- `PWM_FREQ`, 50, PWM frequency in Hz.
  - `PWM_PERIOD = CLK_FREQ/PWM_FREQ`.
  - `PWM_PERIOD` must be ≥ 256; `DIV = PWM_PERIOD/256`.
- `STEP`, 4, duty increment/decrement per PWM period (1..255).
- `HOLD_PERIODS`, 25, PWM periods spent in each hold phase (≥ 1).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle strobe; begins sequencing from IDLE.
- `stop`  in  1  single-cycle strobe; requests return to IDLE.
- `mode`  in  1  0 = all LEDs together, 1 = chase; sampled only on an accepted `start`.
- `leds`  out  8  LED drive.
- `busy`  out  1  high whenever state ≠ IDLE.
- `duty`  out  8  current duty value.
- `cycle_done`  out  1  one-clock pulse at the end of each HOLD_LO phase.

## Operation
- States: IDLE, UP, HOLD_HI, DOWN, HOLD_LO.
- Period counter `cnt`:
  - runs 0..PWM_PERIOD-1 and wraps; held at 0 in IDLE.
  - "Boundary" means the cycle with `cnt == PWM_PERIOD-1`.
- Compare: `threshold = duty*DIV`; PWM output is high when `cnt < threshold`.
  - duty 0 → always low.
  - duty 255 → high for 255·DIV of each period; 100 % duty is never reached.
- IDLE:
  - `start` → UP; `cnt`, `duty`, `idx` cleared; `mode` latched.
  - `start` and `stop` in the same cycle: stop wins, stay IDLE.
- All other transitions and duty changes happen only at a boundary:
  - UP: duty ← min(duty+STEP, 255). If the result is 255 → HOLD_HI with hold count cleared.
  - HOLD_HI: after HOLD_PERIODS boundaries → DOWN; duty unchanged.
  - DOWN: duty ← max(duty−STEP, 0). If the result is 0 → HOLD_LO.
  - HOLD_LO: after HOLD_PERIODS boundaries → UP, `cycle_done` pulses, `idx ← idx+1` (mod 8).
- `stop` while busy:
  - latched into a pending flag.
  - at the next boundary, → IDLE, duty ← 0, leds ← 0, pending cleared.
  - a stop at the boundary cycle itself takes effect at that boundary.
- `start` while busy is ignored.
- LED drive:
  - mode 0: `leds = {8{pwm}}`.
  - mode 1: `leds = pwm << idx`.
- Arithmetic:
  - duty math is 9-bit, then saturated.
  - `cnt` width is clog2(PWM_PERIOD).
  - hold counter width is clog2(HOLD_PERIODS+1).

## Timing
- Reset: state IDLE; `cnt`, `duty`, `idx`, hold count, stop-pending = 0; `leds` = 0, `busy` = 0, `cycle_done` = 0.
- `busy` rises on the clock edge that samples `start`. It falls on the edge that executes the stop boundary.
- `pwm` is registered: `leds` reflects the compare of `cnt` one clock later.
- The duty update at the boundary is visible for the compare at `cnt == 0` of the next period. There is no mixed-duty period.
- `cycle_done` is high for exactly the clock following the HOLD_LO→UP boundary.
- Reset asserted mid-operation forces the reset values immediately, with no boundary wait.

## Structure
- Shared constants go in the project package/include:
  - state encodings: IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4.
  - `DUTY_MAX = 255`.
- Natural sub-module `pwm_core`:
  - contents: period counter, threshold compare, registered `pwm` output.
  - ports: clk, rst_n, enable, duty[7:0], pwm, boundary.
- The sequencer FSM, hold counter, stop latch and LED mapping live in the top module.

## Test plan
Test parameters: CLK_FREQ=2560, PWM_FREQ=10 (PWM_PERIOD=256, DIV=1), STEP=64, HOLD_PERIODS=2.
- Reset, then idle for 1000 clocks → `leds` = 0, `busy` = 0, `duty` = 0 throughout.
- `start` with mode=0:
  - duty at successive boundaries = 64, 128, 192, 255 → HOLD_HI for 2 periods.
  - then 191, 127, 63, 0 → HOLD_LO for 2 periods.
  - then `cycle_done` pulses once; all LEDs show 64 high clocks per period during the 2nd period.
- mode=1, run 9 full cycles → lit LED index goes 0,1,…,7,0; exactly one bit active at a time.
- `stop` mid-period in DOWN → stays busy until the boundary, then IDLE with `leds` = 0; a further `start` restarts from duty 0.
- `start` and `stop` in the same IDLE cycle → remains IDLE. `start` during UP → no effect on duty sequence.
- Assert `rst_n` low for 1 clock at `cnt` = 100 in HOLD_HI → all outputs 0 asynchronously; `busy` = 0 after release.
